// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add unsigned multiplier driving an external combinational ALU
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   reset      - synchronous active-high reset, overrides start
//   start      - multiply request, honoured only in IDLE
//   op_a, op_b - multiplicand / multiplier, captured when start is accepted
//   alu_a/b    - ALU operands (P and gated M while BUSY, zero otherwise)
//   alu_opcode - ADD while BUSY, LD otherwise
//   alu_c      - ALU result, returned in the same cycle
//   alu_status - ALU flags {sign, zero, parity, carry}; only carry is consumed
//   busy, done - BUSY state / one-cycle DONE pulse
//   product    - {P,Q}, the 2N-bit unsigned result
module alu_mul_seq #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     op_a,
    input  logic [DATA_WIDTH-1:0]     op_b,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [4:0]                alu_opcode,
    input  logic [DATA_WIDTH-1:0]     alu_c,
    input  logic [3:0]                alu_status,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   product
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [4:0] OP_LD  = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h02;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_m;
    logic [DATA_WIDTH-1:0] r_p;
    logic [DATA_WIDTH-1:0] r_q;
    logic [CW-1:0]         r_count;
    logic                  w_last;
    logic                  w_unused;

    // only the carry flag matters to the shift-add loop
    assign w_unused = ^alu_status[3:1];
    assign w_last   = r_count == CW'(DATA_WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_m     <= op_a;
                r_p     <= '0;
                r_q     <= op_b;
                r_count <= '0;
            end else if (r_state == S_BUSY) begin
                // the ADD carry becomes the new MSB of P as the pair shifts right
                {r_p, r_q} <= {alu_status[0], alu_c, r_q[DATA_WIDTH-1:1]};
                r_count    <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = OP_LD;
        busy       = r_state == S_BUSY;
        done       = r_state == S_DONE;
        if (r_state == S_IDLE) begin
            w_next = start ? S_BUSY : S_IDLE;
        end else if (r_state == S_BUSY) begin
            alu_opcode = OP_ADD;
            alu_a      = r_p;
            alu_b      = r_q[0] ? r_m : '0;
            w_next     = w_last ? S_DONE : S_BUSY;
        end else begin
            w_next = S_IDLE;
        end
    end

    assign product = {r_p, r_q};
endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand width N; product is 2N bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port op_a  input  N  multiplicand; captured on accepted start.
REQ-006 SHALL have port op_b  input  N  multiplier; captured on accepted start.
REQ-007 SHALL have port alu_a  output  N  to ALU input A.
REQ-008 SHALL have port alu_b  output  N  to ALU input B.
REQ-009 SHALL have port alu_opcode  output  5  to ALU opcode.
REQ-010 SHALL have port alu_c  input  N  ALU result C (combinational return).
REQ-011 SHALL have port alu_status  input  4  ALU status {sign, zero, parity, carry}; only bit 0 (carry) is used.
REQ-012 SHALL have port busy  output  1  high while in BUSY.
REQ-013 SHALL have port done  output  1  one-cycle pulse when product is valid.
REQ-014 SHALL have port product  output  2N  unsigned op_a*op_b.

Function
REQ-015 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE, with no other states.
REQ-016 SHALL contain internal registers: M (N), P (accumulator high half, N), Q (multiplier / low half, N), count (ceil(log2(N+1)) bits).
REQ-017 In IDLE with start=1: M<=op_a, P<=0, Q<=op_b, count<=0, next state BUSY; start=0 leaves all registers unchanged.
REQ-018 In IDLE and DONE, SHALL drive alu_a=0, alu_b=0, alu_opcode=5'h00 (LD).
REQ-019 In BUSY, SHALL drive alu_opcode=5'h02 (ADD), alu_a=P, alu_b=(Q[0] ? M : 0).
REQ-020 Each BUSY cycle SHALL update {P,Q} <= {alu_status[0], alu_c, Q[N-1:1]} (the carry-in becomes the MSB of P), and count<=count+1.
REQ-021 BUSY SHALL last exactly N cycles; on the cycle count==N-1, next state is DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 product SHALL equal {P,Q} at all times; it is valid from the DONE cycle and held unchanged until the next accepted start.
REQ-024 Latency: start sampled at edge k -> done=1 during the cycle after edge k+N; total N+1 cycles from start to done.
REQ-025 start SHALL be ignored in BUSY and DONE, with no queuing; a start held high through DONE is accepted in the following IDLE cycle.
REQ-026 op_a/op_b changes after acceptance SHALL NOT affect the result.
REQ-027 busy SHALL be 1 iff state==BUSY; done SHALL be 1 iff state==DONE.
REQ-028 The arithmetic SHALL be unsigned; the result is exact for all inputs with no overflow (max (2^N-1)^2 fits in 2N bits).
REQ-029 The block SHALL rely on the ALU ADD carry appearing on alu_status[0] in the same cycle, with no registered path inside the ALU.

Reset
REQ-030 reset=1 at an edge SHALL force state=IDLE and clear M, P, Q and count to 0, regardless of state.
REQ-031 After reset, outputs SHALL be busy=0, done=0, product=0, alu_a=0, alu_b=0, alu_opcode=5'h00.
REQ-032 reset SHALL take priority over start in the same cycle.
REQ-033 Reset mid-BUSY SHALL abort the operation with no done pulse.

Verification
REQ-034 N=8, op_a=13, op_b=11, start one cycle -> busy high 8 cycles, done pulse on cycle 9, product=16'h008F.
REQ-035 N=8, op_a=255, op_b=255 -> product=16'hFE01; check carry-in used (P MSB set in final iterations).
REQ-036 op_a=0, op_b=200 and op_a=200, op_b=0 -> product=0; alu_b=0 every BUSY cycle for op_b=0.
REQ-037 start pulsed again mid-BUSY with new operands -> ignored; 13*11 still yields 16'h008F, single done pulse.
REQ-038 reset asserted at BUSY cycle 4 -> next cycle busy=0, product=0, no done; subsequent 7*6 run -> product=16'h002A.
REQ-039 start held high continuously -> back-to-back operations, one done pulse per N+2 cycles, each product correct.
